// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, sequencer state encoding and op-select codes.
package alu_pkg;

  // Width of one adder slice; operands are a whole number of slices.
  localparam int SLICE_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Values of the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_16_bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with a group lookahead stage.
// Group propagate/generate are exported so slices can be cascaded in a larger lookahead tree.
module cla_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        p_grp,
  output logic        g_grp
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  // Per-group propagate and generate.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (&p[4*j+2 +: 2] & g[4*j+1])
            | (&p[4*j+1 +: 3] & g[4*j]);
    end
  end

  // Second-level lookahead: carry into each group computed directly from cin.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (&gp[1:0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (&gp[2:1] & gg[0]) | (&gp[2:0] & cin);

  assign p_grp = &gp;
  assign g_grp = gg[3] | (gp[3] & gg[2]) | (&gp[3:2] & gg[1]) | (&gp[3:1] & gg[0]);
  assign gc[4] = g_grp | (p_grp & cin);
  assign cout  = gc[4];

  // Bit carries inside each group, looked ahead from that group's carry-in.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (&p[4*j +: 2] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (&p[4*j+1 +: 2] & g[4*j])
               | (&p[4*j +: 3] & gc[j]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WORDS x 16-bit add/subtract built on a single cla_16_bit slice.
// One slice per cycle, least-significant first; the slice carry is registered between cycles.
module cla_seq_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic                     cin,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  output logic                     busy,
  output logic                     done,
  output logic [SLICE_W*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int              W        = SLICE_W * WORDS;
  localparam int              IDXW     = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            accept;
  logic            last;
  logic [15:0]     cla_a;
  logic [15:0]     cla_b;
  logic [15:0]     cla_sum;
  logic            cla_cout;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state always uses non-blocking (<=) so every register sees pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state, accept strobe and last-slice flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle is taken immediately for back-to-back issue.
        if (start) begin
          accept  = 1'b1;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);

  // Current slice of each operand register feeds the shared adder.
  assign cla_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign cla_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  // Group P/G are only useful when cascading slices combinationally, which this block does not do.
  cla_16_bit u_slice (
    .a     (cla_a),
    .b     (cla_b),
    .cin   (carry_q),
    .sum   (cla_sum),
    .cout  (cla_cout),
    .p_grp (),
    .g_grp ()
  );

  // Operand capture on accept, then slice-by-slice write-back of sum and carry chaining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the operand registers are plain flops rather than a memory array, so they take
      // the async reset like every other register and an aborted operation leaves nothing behind.
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= (sub == OP_SUB) ? ~in_b : in_b;
      carry_q <= (sub == OP_SUB) ? 1'b1 : cin;
      idx_q   <= '0;
    end else if (state_q == ADD) begin
      sum[int'(idx_q)*SLICE_W +: SLICE_W] <= cla_sum;
      carry_q <= cla_cout;
      if (last) begin
        cout <= cla_cout;
        // Signed overflow: operands agree in sign but the result does not.
        ovf  <= (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE_W-1] != a_q[W-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl: directed vector table, handshake and async-reset
// sequences, and randomized add/sub against an arithmetic reference model at WORDS=4 and WORDS=2.
module tb_cla_seq_adder_ctrl;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        start4 = 1'b0;
  logic        start2 = 1'b0;
  logic        sub    = 1'b0;
  logic        cin    = 1'b0;
  logic [63:0] in_a   = '0;
  logic [63:0] in_b   = '0;

  logic        busy4, done4, cout4, ovf4;
  logic [63:0] sum4;
  logic        busy2, done2, cout2, ovf2;
  logic [31:0] sum2;

  int n_checks = 0;
  int n_err    = 0;

  cla_seq_adder_ctrl #(.WORDS(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .sub   (sub),
    .cin   (cin),
    .in_a  (in_a),
    .in_b  (in_b),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  cla_seq_adder_ctrl #(.WORDS(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .sub   (sub),
    .cin   (cin),
    .in_a  (in_a[31:0]),
    .in_b  (in_b[31:0]),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2),
    .ovf   (ovf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: n-bit modular arithmetic for sum/cout, exact signed arithmetic for overflow.
  task automatic ref_model(input int n, input logic s, input logic c,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] rs, output logic rc, output logic ro);
    logic [64:0]        m65;
    logic [63:0]        m;
    logic [65:0]        full;
    logic signed [66:0] sa, sb, r, lim;
    m65 = (65'd1 << n) - 65'd1;
    m   = m65[63:0];
    if (s) begin
      rs = (a - b) & m;
      rc = (a >= b);
    end else begin
      full = {2'b00, a} + {2'b00, b} + {65'd0, c};
      rs   = full[63:0] & m;
      rc   = full[n];
    end
    sa = {3'b000, a};
    sb = {3'b000, b};
    if (a[n-1]) sa = sa - (67'sd1 <<< n);
    if (b[n-1]) sb = sb - (67'sd1 <<< n);
    r   = s ? (sa - sb) : (sa + sb + {66'd0, c});
    lim = 67'sd1 <<< (n - 1);
    ro  = (r >= lim) || (r < -lim);
  endtask

  // Issue one operation on the WORDS=w instance and wait (bounded) for its done pulse.
  // Inputs are scrambled right after the accept edge; the result must not depend on them.
  task automatic run_op(input int w, input logic s, input logic c,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] rs, output logic rc, output logic ro,
                        output int lat);
    logic got;
    @(negedge clk);
    sub  = s;
    cin  = c;
    in_a = a;
    in_b = b;
    if (w == 4) start4 = 1'b1;
    else        start2 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start2 = 1'b0;
    in_a   = {$urandom(), $urandom()};
    in_b   = {$urandom(), $urandom()};
    sub    = 1'(~s);
    cin    = 1'($urandom_range(0, 1));
    lat    = 0;
    got    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if ((w == 4) ? done4 : done2) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", {63'd0, got}, 64'd1);
    rs = (w == 4) ? sum4 : {32'd0, sum2};
    rc = (w == 4) ? cout4 : cout2;
    ro = (w == 4) ? ovf4 : ovf2;
  endtask

  initial begin
    logic [63:0] rs, es, m;
    logic        rc, ro, ec, eo;
    int          lat;
    int          pulses;
    logic [63:0] xa [16];
    logic [63:0] xb [16];
    logic        xs [16];
    logic        xc [16];

    vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 64'd10, 64'd3, 64'd7, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 1'b0, 1'b0};

    // Reset state of both instances while rst is held low.
    #1;
    check("rst_flags4", {60'd0, busy4, done4, cout4, ovf4}, 64'd0);
    check("rst_sum4", sum4, 64'd0);
    check("rst_flags2", {60'd0, busy2, done2, cout2, ovf2}, 64'd0);
    check("rst_sum2", {32'd0, sum2}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors at WORDS=4, with latency on every operation.
    for (int i = 0; i < 9; i++) begin
      run_op(4, vecs[i].s, vecs[i].c, vecs[i].a, vecs[i].b, rs, rc, ro, lat);
      check("vec_sum", rs, vecs[i].e_sum);
      check("vec_cout", {63'd0, rc}, {63'd0, vecs[i].e_cout});
      check("vec_ovf", {63'd0, ro}, {63'd0, vecs[i].e_ovf});
      check("vec_latency", 64'(lat), 64'd5);
      check("vec_busy_in_done", {63'd0, busy4}, 64'd0);
    end

    // start held high with operands changing every cycle: accepts every 5 cycles only.
    @(negedge clk);
    xa[0] = {$urandom(), $urandom()};
    xb[0] = {$urandom(), $urandom()};
    xs[0] = 1'($urandom_range(0, 1));
    xc[0] = 1'($urandom_range(0, 1));
    in_a = xa[0]; in_b = xb[0]; sub = xs[0]; cin = xc[0];
    start4 = 1'b1;
    for (int n = 1; n < 16; n++) begin
      @(negedge clk);
      check("hs_busy_done", {62'd0, busy4, done4},
            (n % 5 == 0) ? 64'd1 : 64'd2);
      if (n % 5 == 0) begin
        ref_model(64, xs[n-5], xc[n-5], xa[n-5], xb[n-5], es, ec, eo);
        check("hs_sum", sum4, es);
        check("hs_cout_ovf", {62'd0, cout4, ovf4}, {62'd0, ec, eo});
      end
      if (n < 15) begin
        xa[n] = {$urandom(), $urandom()};
        xb[n] = {$urandom(), $urandom()};
        xs[n] = 1'($urandom_range(0, 1));
        xc[n] = 1'($urandom_range(0, 1));
        in_a = xa[n]; in_b = xb[n]; sub = xs[n]; cin = xc[n];
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);
    check("hs_idle_after", {62'd0, busy4, done4}, 64'd0);

    // Leave cout/ovf set, then abort a new operation at slice index 2 with an async reset.
    run_op(4, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, rs, rc, ro, lat);
    check("pre_rst_cout_ovf", {62'd0, rc, ro}, 64'd3);
    @(negedge clk);
    sub = 1'b0; cin = 1'b0;
    in_a = 64'h1111_2222_3333_4444;
    in_b = 64'h1111_1111_1111_1111;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_op_busy", {63'd0, busy4}, 64'd1);
    check("mid_op_low_slices", {32'd0, sum4[31:0]}, 64'h4444_5555);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_flags", {60'd0, busy4, done4, cout4, ovf4}, 64'd0);
    check("async_rst_sum", sum4, 64'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      if (done4) pulses++;
    end
    check("no_done_after_abort", 64'(pulses), 64'd0);
    run_op(4, 1'b0, 1'b0, 64'd3, 64'd4, rs, rc, ro, lat);
    check("post_rst_sum", rs, 64'd7);
    check("post_rst_cout_ovf", {62'd0, rc, ro}, 64'd0);

    // Randomized operations against the reference model, at 64 and 32 bits.
    for (int wi = 0; wi < 2; wi++) begin
      int w;
      int nb;
      logic [63:0] a, b;
      logic        s, c;
      w  = (wi == 0) ? 4 : 2;
      nb = 16 * w;
      m  = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      for (int i = 0; i < 1000; i++) begin
        a = {$urandom(), $urandom()} & m;
        b = {$urandom(), $urandom()} & m;
        case ($urandom_range(0, 7))
          0: a = m;
          1: b = m;
          2: a = m >> 1;
          3: b = (m >> 1) + 64'd1 & m;
          default: ;
        endcase
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        run_op(w, s, c, a, b, rs, rc, ro, lat);
        ref_model(nb, s, c, a, b, es, ec, eo);
        check((w == 4) ? "rnd4_sum" : "rnd2_sum", rs, es);
        check((w == 4) ? "rnd4_cout" : "rnd2_cout", {63'd0, rc}, {63'd0, ec});
        check((w == 4) ? "rnd4_ovf" : "rnd2_ovf", {63'd0, ro}, {63'd0, eo});
      end
      check((w == 4) ? "rnd4_latency" : "rnd2_latency", 64'(lat), 64'(w + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
